// File: rtl/led_fader.sv
// led_fader: per-LED PWM output stage with brightness control and a decaying
// afterglow tail for the chasing-LED pattern generator.
// Optional build macro LED_FADER_GAMMA_EN: compare a squared (perceptual)
// level against the PWM counter instead of the linear level.
module led_fader #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DECAY_DIV  = 50000,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          pattern_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_level,
  output logic [7:0]          led_out_n,
  output logic                glow_active
);

  localparam int unsigned DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [DCW-1:0]      DECAY_LAST = DCW'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] STEP_W     = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DCW-1:0]      decay_cnt_q, decay_cnt_d;
  logic [PWM_BITS-1:0] level_q [8];
  logic [PWM_BITS-1:0] level_d [8];
  logic [PWM_BITS-1:0] cmp_level [8];
  logic [7:0]          led_out_q, led_out_d;
  logic                glow_q, glow_d;
  logic                tick;

  // PWM period counter (skips the all-ones value) and decay tick divider
  always_comb begin
    tick        = (decay_cnt_q == DECAY_LAST);
    pwm_cnt_d   = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    decay_cnt_d = tick ? '0 : decay_cnt_q + DCW'(1);
    if (!enable) begin
      pwm_cnt_d   = '0;
      decay_cnt_d = '0;
    end
  end

  // Per-channel level: lit loads max_level (beats a tick), else saturating decay
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      if (!enable) begin
        level_d[i] = '0;
      end else if (!pattern_n[i]) begin
        level_d[i] = max_level;
      end else if (tick) begin
        level_d[i] = (32'(level_q[i]) > DECAY_STEP) ? level_q[i] - STEP_W : '0;
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq [8];

  // Perceptual level: square of the level scaled back to PWM_BITS
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      level_sq[i]  = (2*PWM_BITS)'(level_q[i]) * (2*PWM_BITS)'(level_q[i]);
      cmp_level[i] = level_sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  // Linear level drives the PWM comparison directly
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      cmp_level[i] = level_q[i];
    end
  end
`endif

  // Next output pins and glow flag, derived from the current registers
  always_comb begin
    glow_d = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      led_out_d[i] = ~(cmp_level[i] > pwm_cnt_q);
      glow_d       = glow_d | (level_q[i] != '0);
    end
    if (!enable) begin
      led_out_d = '1;
      glow_d    = 1'b0;
    end
  end

  // State registers, cleared asynchronously by rst low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
      level_q     <= '{default: '0};
      led_out_q   <= '1;
      glow_q      <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      level_q     <= level_d;
      led_out_q   <= led_out_d;
      glow_q      <= glow_d;
    end
  end

  assign led_out_n   = led_out_q;
  assign glow_active = glow_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=5),
// plus a second instance with DECAY_DIV=1, DECAY_STEP=4 for saturation.
module tb_led_fader;

`ifdef LED_FADER_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif
  localparam int DDIV = 4;
  localparam int STEP = 5;

  logic       clk;
  logic       rst;
  logic [7:0] pattern_n;
  logic       enable;
  logic [3:0] max_level;
  logic [7:0] led_out_n, led4_n;
  logic       glow_active, glow4;

  led_fader #(.PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(5)) dut (
    .clk(clk), .rst(rst), .pattern_n(pattern_n), .enable(enable),
    .max_level(max_level), .led_out_n(led_out_n), .glow_active(glow_active));

  led_fader #(.PWM_BITS(4), .DECAY_DIV(1), .DECAY_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .pattern_n(pattern_n), .enable(enable),
    .max_level(max_level), .led_out_n(led4_n), .glow_active(glow4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_lvl [8];
  int         m_pwm;
  int         m_dcnt;
  logic [7:0] m_led;
  logic       m_glow;

  typedef struct {
    logic [7:0] led;
    logic       glow;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] pat;
    logic       en;
    logic [3:0] mx;
    int         bitn;
    int         lin;
    int         gam;
    logic       glow;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int perc(input int l);
    return GAMMA ? ((l * l) >> 4) : l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    m_pwm  = 0;
    m_dcnt = 0;
    m_led  = 8'hFF;
    m_glow = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] pat, input logic en, input logic [3:0] mx);
    logic [7:0] nl;
    logic       any;
    bit         tk;
    if (!en) begin
      model_clear();
    end else begin
      tk  = (m_dcnt == DDIV - 1);
      any = 1'b0;
      for (int i = 0; i < 8; i++) begin
        nl[i] = !(perc(m_lvl[i]) > m_pwm);
        if (m_lvl[i] != 0) any = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        if (!pat[i]) m_lvl[i] = int'(mx);
        else if (tk) m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
      end
      m_pwm  = (m_pwm == 14) ? 0 : m_pwm + 1;
      m_dcnt = tk ? 0 : m_dcnt + 1;
      m_led  = nl;
      m_glow = any;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, score the result after the rise
  task automatic step(input logic [7:0] pat, input logic en, input logic [3:0] mx);
    exp_t e;
    pattern_n = pat;
    enable    = en;
    max_level = mx;
    model_edge(pat, en, mx);
    sbq.push_back('{led: m_led, glow: m_glow});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_led", 32'(led_out_n), 32'(e.led));
    chk("sb_glow", 32'(glow_active), 32'(e.glow));
    @(negedge clk);
  endtask

  initial begin
    int cnt, cnt4, guard;
    logic [7:0] led_and;
    logic       glow_or;

    vecs[0] = '{8'hFE, 1'b1, 4'd15, 0, 15, 14, 1'b1};
    vecs[1] = '{8'hF7, 1'b1, 4'd6,  3, 6,  2,  1'b1};
    vecs[2] = '{8'hFB, 1'b1, 4'd8,  2, 8,  4,  1'b1};
    vecs[3] = '{8'hFE, 1'b1, 4'd1,  0, 1,  0,  1'b1};
    vecs[4] = '{8'h7F, 1'b1, 4'd10, 7, 10, 6,  1'b1};
    vecs[5] = '{8'h00, 1'b0, 4'd15, 0, 0,  0,  1'b0};
    vecs[6] = '{8'hFF, 1'b1, 4'd15, 4, 0,  0,  1'b0};
    vecs[7] = '{8'h00, 1'b1, 4'd0,  5, 0,  0,  1'b0};

    rst = 1'b0;
    pattern_n = 8'hFF;
    enable = 1'b0;
    max_level = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset_led", 32'(led_out_n), 32'h0FF);
    chk("reset_glow", 32'(glow_active), 32'h0);
    rst = 1'b1;

    // steady-state duty per brightness, measured over one full 15-cycle period
    for (int r = 0; r < 8; r++) begin
      cnt = 0;
      for (int k = 1; k <= 17; k++) begin
        step(vecs[r].pat, vecs[r].en, vecs[r].mx);
        if (k > 2 && !led_out_n[vecs[r].bitn]) cnt++;
      end
      chk($sformatf("duty_v%0d", r), 32'(cnt), 32'(GAMMA ? vecs[r].gam : vecs[r].lin));
      chk($sformatf("glow_v%0d", r), 32'(glow_active), 32'(vecs[r].glow));
    end

    // decay 15->10->5->0, release aligned so the first tick is 4 edges later
    for (int k = 0; k < 20; k++) step(8'hFE, 1'b1, 4'd15);
    guard = 0;
    while (m_dcnt != 0 && guard < 8) begin
      step(8'hFE, 1'b1, 4'd15);
      guard++;
    end
    chk("decay_align", 32'(m_dcnt), 32'h0);
    cnt = 0;
    cnt4 = 0;
    for (int k = 0; k < 20; k++) begin
      step(8'hFF, 1'b1, 4'd15);
      if (glow_active) cnt++;
      if (glow4) cnt4++;
    end
    chk("decay_glow_len", 32'(cnt), 32'd12);
    chk("decay4_sat_len", 32'(cnt4), 32'd4);

    // lit on the same edge as a tick: full level, no decrement
    guard = 0;
    while (m_dcnt != DDIV - 1 && guard < 8) begin
      step(8'hFF, 1'b1, 4'd15);
      guard++;
    end
    chk("prio_align", 32'(m_dcnt), 32'(DDIV - 1));
    step(8'hFB, 1'b1, 4'd15);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(8'hFF, 1'b1, 4'd15);
      if (glow_active) cnt++;
    end
    chk("prio_glow_len", 32'(cnt), 32'd12);

    // one-cycle enable drop
    for (int k = 0; k < 3; k++) step(8'hFE, 1'b1, 4'd15);
    step(8'hFE, 1'b0, 4'd15);
    chk("en_drop_led", 32'(led_out_n), 32'h0FF);
    chk("en_drop_glow", 32'(glow_active), 32'h0);
    for (int k = 0; k < 5; k++) step(8'hFE, 1'b1, 4'd15);

    // random traffic against the model
    for (int k = 0; k < 200; k++)
      step(8'($urandom | $urandom), ($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)));

    // reset in the middle of a fade
    for (int k = 0; k < 6; k++) step(8'h00, 1'b1, 4'd15);
    step(8'hFF, 1'b1, 4'd15);
    step(8'hFF, 1'b1, 4'd15);
    rst = 1'b0;
    #1;
    chk("midreset_led", 32'(led_out_n), 32'h0FF);
    chk("midreset_glow", 32'(glow_active), 32'h0);
    chk("midreset_glow4", 32'(glow4), 32'h0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    led_and = 8'hFF;
    glow_or = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(8'hFF, 1'b1, 4'd15);
      led_and = led_and & led_out_n;
      glow_or = glow_or | glow_active;
    end
    chk("post_reset_dark", 32'(led_and), 32'h0FF);
    chk("post_reset_glow", 32'(glow_or), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
